// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one single-port synchronous RAM between an instruction-fetch
//   requester (read-only) and a data requester (read/write). Grants are
//   combinational in the request cycle. A small tracker FSM routes the
//   read data that returns one cycle later back to the requester that
//   issued the read.
//
//   Optional feature macro: RAM_ARB_STARVE_GUARD_EN
//     defined   : a 4-bit starvation counter lets fetch win over data after
//                 STARVE_LIMIT consecutive denied fetch cycles.
//     undefined : strict data priority; fetch may starve indefinitely.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   if_req_i, if_addr_i     fetch request and address
//   if_gnt_o                fetch granted this cycle
//   if_rvalid_o, if_rdata_o fetch read response (one cycle after grant)
//   dm_req_i, dm_we_i       data request, write enable
//   dm_addr_i, dm_wdata_i   data address, write data
//   dm_be_i                 data byte enables
//   dm_gnt_o                data granted this cycle
//   dm_rvalid_o, dm_rdata_o data read response (one cycle after grant)
//   flush_i                 cancels the in-flight fetch response
//   ram_en_o, ram_we_o      RAM enable, write enable
//   ram_addr_o, ram_wdata_o RAM address, write data
//   ram_be_o                RAM byte enables
//   ram_rdata_i             RAM read data, valid one cycle after a read
module ram_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  if_req_i,
    input  logic [ADDR_W-1:0]     if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_W-1:0]     if_rdata_o,

    input  logic                  dm_req_i,
    input  logic                  dm_we_i,
    input  logic [ADDR_W-1:0]     dm_addr_i,
    input  logic [DATA_W-1:0]     dm_wdata_i,
    input  logic [DATA_W/8-1:0]   dm_be_i,
    output logic                  dm_gnt_o,
    output logic                  dm_rvalid_o,
    output logic [DATA_W-1:0]     dm_rdata_o,

    input  logic                  flush_i,

    output logic                  ram_en_o,
    output logic                  ram_we_o,
    output logic [ADDR_W-1:0]     ram_addr_o,
    output logic [DATA_W-1:0]     ram_wdata_o,
    output logic [DATA_W/8-1:0]   ram_be_o,
    input  logic [DATA_W-1:0]     ram_rdata_i
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_IF = 2'd1,
        RD_DM = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   flush_q, flush_d;
    logic   if_gnt, dm_gnt;
    logic   starve_fire;

`ifdef RAM_ARB_STARVE_GUARD_EN
    logic [3:0] starve_q, starve_d;

    assign starve_fire = (starve_q == 4'(STARVE_LIMIT));

    // Counts consecutive cycles fetch was asking but lost; any fetch grant
    // or a dropped fetch request restarts the count.
    always_comb begin
        starve_d = starve_q;
        if (!if_req_i || if_gnt) begin
            starve_d = '0;
        end else begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign starve_fire = 1'b0;
`endif

    // Data wins by default; fetch only when data is idle or the guard fires.
    // Reset forces both grants low regardless of requests.
    assign if_gnt = !rst_i && if_req_i && (!dm_req_i || starve_fire);
    assign dm_gnt = !rst_i && dm_req_i && !if_gnt;

    assign if_gnt_o = if_gnt;
    assign dm_gnt_o = dm_gnt;

    // RAM port is steered from whichever requester holds the grant.
    always_comb begin
        ram_en_o    = if_gnt || dm_gnt;
        ram_we_o    = dm_gnt && dm_we_i;
        ram_addr_o  = dm_gnt ? dm_addr_i : if_addr_i;
        ram_wdata_o = dm_gnt ? dm_wdata_i : '0;
        ram_be_o    = dm_gnt ? dm_be_i : {BE_W{1'b0}};
    end

    // Tracker state register; flush_q remembers a flush seen in the cycle
    // the fetch was granted so its response can be dropped next cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
        end
    end

    // Next state depends only on this cycle's grant, so back-to-back
    // accesses are tracked at one per cycle.
    always_comb begin
        state_d = IDLE;
        flush_d = 1'b0;
        if (if_gnt) begin
            state_d = RD_IF;
            flush_d = flush_i;
        end else if (dm_gnt && !dm_we_i) begin
            state_d = RD_DM;
        end
    end

    // Response routing. rdata always follows the RAM so no latch is formed.
    always_comb begin
        if_rdata_o  = ram_rdata_i;
        dm_rdata_o  = ram_rdata_i;
        if_rvalid_o = 1'b0;
        dm_rvalid_o = 1'b0;
        unique case (state_q)
            RD_IF:   if_rvalid_o = !rst_i && !flush_q && !flush_i;
            RD_DM:   dm_rvalid_o = !rst_i;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BW  = DW / 8;
    localparam int LIM = 4;
`ifdef RAM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          if_req_i, dm_req_i, dm_we_i, flush_i;
    logic [AW-1:0] if_addr_i, dm_addr_i;
    logic [DW-1:0] dm_wdata_i;
    logic [BW-1:0] dm_be_i;
    logic          if_gnt_o, if_rvalid_o, dm_gnt_o, dm_rvalid_o;
    logic [DW-1:0] if_rdata_o, dm_rdata_o;
    logic          ram_en_o, ram_we_o;
    logic [AW-1:0] ram_addr_o;
    logic [DW-1:0] ram_wdata_o;
    logic [BW-1:0] ram_be_o;
    logic [DW-1:0] ram_rdata_i;

    always #5 clk_i = ~clk_i;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_be_i(dm_be_i), .dm_gnt_o(dm_gnt_o),
        .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
        .flush_i(flush_i),
        .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o), .ram_be_o(ram_be_o), .ram_rdata_i(ram_rdata_i)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    endtask

    function automatic logic [31:0] init_word(input int idx);
        if (idx == 4) return 32'hDEADBEEF;
        return (32'(idx) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Environment RAM: one-cycle read latency, byte-enable writes.
    logic [31:0] env_mem [256];
    bit          env_wr  [256];
    always @(posedge clk_i) begin : env_ram
        logic [31:0] w;
        int          i;
        i = int'(ram_addr_o[9:2]);
        w = env_wr[i] ? env_mem[i] : init_word(i);
        if (ram_en_o && ram_we_o) begin
            for (int b = 0; b < BW; b++)
                if (ram_be_o[b]) w[b*8 +: 8] = ram_wdata_o[b*8 +: 8];
            env_mem[i] <= w;
            env_wr[i]  <= 1'b1;
            ram_rdata_i <= $urandom;
        end else if (ram_en_o) begin
            ram_rdata_i <= w;
        end else begin
            ram_rdata_i <= $urandom;
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [256];
    int          m_cnt = 0;

    typedef struct {
        int          cyc;
        bit          is_if;
        bit          fl;
        logic [31:0] data;
    } resp_t;
    resp_t sb[$];

    // One cycle of stimulus; model predicts grants/RAM controls and queues
    // the read response expected next cycle.
    task automatic step(input bit rst, input bit ireq, input logic [31:0] iaddr,
                        input bit dreq, input bit dwe, input logic [31:0] daddr,
                        input logic [31:0] wd, input logic [3:0] be, input bit fl);
        bit    e_if, e_dm, fire;
        resp_t r;
        logic [31:0] w;
        @(posedge clk_i);
        cyc++;
        #1;
        rst_i = rst; if_req_i = ireq; if_addr_i = iaddr; dm_req_i = dreq;
        dm_we_i = dwe; dm_addr_i = daddr; dm_wdata_i = wd; dm_be_i = be; flush_i = fl;
        #1;
        fire = GUARD && (m_cnt == LIM);
        e_if = !rst && ireq && (!dreq || fire);
        e_dm = !rst && dreq && !e_if;
        check("if_gnt", 64'(if_gnt_o), 64'(e_if));
        check("dm_gnt", 64'(dm_gnt_o), 64'(e_dm));
        check("ram_en", 64'(ram_en_o), 64'(e_if || e_dm));
        check("ram_we", 64'(ram_we_o), 64'(e_dm && dwe));
        if (e_if) check("ram_addr_if", 64'(ram_addr_o), 64'(iaddr));
        if (e_dm) check("ram_addr_dm", 64'(ram_addr_o), 64'(daddr));
        if (e_dm && dwe) begin
            check("ram_wdata", 64'(ram_wdata_o), 64'(wd));
            check("ram_be", 64'(ram_be_o), 64'(be));
        end
        if (rst || !ireq || e_if) m_cnt = 0;
        else m_cnt++;
        if (e_if) begin
            r.cyc = cyc + 1; r.is_if = 1'b1; r.fl = fl; r.data = ref_mem[iaddr[9:2]];
            sb.push_back(r);
        end else if (e_dm && !dwe) begin
            r.cyc = cyc + 1; r.is_if = 1'b0; r.fl = 1'b0; r.data = ref_mem[daddr[9:2]];
            sb.push_back(r);
        end else if (e_dm && dwe) begin
            w = ref_mem[daddr[9:2]];
            for (int b = 0; b < BW; b++)
                if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
            ref_mem[daddr[9:2]] = w;
        end
    endtask

    task automatic idle(input bit fl);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, fl);
    endtask

    // Monitor: compares response outputs against the scoreboard each cycle.
    initial begin : monitor
        resp_t e;
        bit    have, x_if, x_dm;
        forever begin
            @(negedge clk_i);
            if (cyc > 0) begin
                have = 1'b0;
                while (sb.size() > 0 && sb[0].cyc < cyc) void'(sb.pop_front());
                if (sb.size() > 0 && sb[0].cyc == cyc) begin
                    e = sb.pop_front();
                    have = 1'b1;
                end
                x_if = have && e.is_if && !e.fl && !flush_i && !rst_i;
                x_dm = have && !e.is_if && !rst_i;
                check("if_rvalid", 64'(if_rvalid_o), 64'(x_if));
                check("dm_rvalid", 64'(dm_rvalid_o), 64'(x_dm));
                if (x_if) check("if_rdata", 64'(if_rdata_o), 64'(e.data));
                if (x_dm) check("dm_rdata", 64'(dm_rdata_o), 64'(e.data));
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1);
    end

    initial begin : main
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        rst_i = 1'b1; if_req_i = 1'b0; dm_req_i = 1'b0; dm_we_i = 1'b0; flush_i = 1'b0;
        if_addr_i = '0; dm_addr_i = '0; dm_wdata_i = '0; dm_be_i = '0;

        // Reset with both requesters asking: nothing granted.
        repeat (2) step(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
        check("rst_if_gnt", 64'(if_gnt_o), 64'd0);
        idle(1'b0);

        // Fetch only from 0x10.
        step(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        check("fetch_gnt", 64'(if_gnt_o), 64'd1);
        idle(1'b0);
        check("fetch_rvalid", 64'(if_rvalid_o), 64'd1);
        check("fetch_rdata", 64'(if_rdata_o), 64'hDEADBEEF);

        // Both requesting continuously.
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b1, 32'h30, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
            check("starve_pattern", 64'(if_gnt_o), 64'(GUARD && (k == 4 || k == 9)));
        end
        idle(1'b0);

        // Data write: RAM write same cycle, no read response after.
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h12345678, 4'hF, 1'b0);
        check("write_we", 64'(ram_we_o), 64'd1);
        idle(1'b0);
        check("write_no_rvalid", 64'(dm_rvalid_o), 64'd0);
        // Read it back.
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0);
        idle(1'b0);
        check("write_readback", 64'(dm_rdata_o), 64'h12345678);

        // Flush in the response cycle, then flush in the grant cycle.
        step(1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        idle(1'b1);
        check("flush_resp", 64'(if_rvalid_o), 64'd0);
        step(1'b0, 1'b1, 32'hC, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        check("flush_gnt_allowed", 64'(if_gnt_o), 64'd1);
        idle(1'b0);
        check("flush_grant_cycle", 64'(if_rvalid_o), 64'd0);

        // Alternating data/fetch reads back-to-back.
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'(k * 4 + 64), 32'h0, 4'h0, 1'b0);
            else            step(1'b0, 1'b1, 32'(k * 4 + 128), 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        end
        idle(1'b0);

        // Fetch granted, reset the next cycle.
        step(1'b0, 1'b1, 32'h14, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        step(1'b1, 1'b1, 32'h18, 1'b1, 1'b1, 32'h1C, 32'hFFFFFFFF, 4'hF, 1'b0);
        check("rst_rvalid", 64'(if_rvalid_o), 64'd0);
        check("rst_ram_en", 64'(ram_en_o), 64'd0);
        idle(1'b0);
        check("post_rst_rvalid", 64'(if_rvalid_o), 64'd0);

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 39) == 0,
                 1'($urandom), {24'h0, 6'($urandom), 2'b00},
                 1'($urandom), $urandom_range(0, 2) == 0, {24'h0, 6'($urandom), 2'b00},
                 $urandom, 4'($urandom), $urandom_range(0, 4) == 0);
        end
        repeat (3) idle(1'b0);
        @(negedge clk_i);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
